cpu_run_ctrl: RTL and testbench

Synthesizable run controller that sequences reset and execution of `cpu_top` for bring-up, on-board self-test and regression benches. It replaces fixed-delay stimulus (hold reset, run a fixed time, stop) with a parametrised FSM. The FSM supports programmable reset-hold length, a bounded or unbounded run, single-step execution, halt detection and abort. It sits between the system clock/reset and the CPU's `rst` input and clock-enable, and exposes a cycle counter and completion status.

---
 rtl/cpu_run_ctrl_if.sv | 34 +++
 rtl/cpu_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between a run controller and whatever sequences it.
//   master : start, mode, step, halt_in, abort (drives)
//            cpu_rst, cpu_ce, cycle_count, busy, done, halted, timed_out, aborted (observes)
//   slave  : the cpu_run_ctrl side, mirror image of master
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             start;
  logic [1:0]       mode;
  logic             step;
  logic             halt_in;
  logic             abort;

  logic             cpu_rst;
  logic             cpu_ce;
  logic [CNT_W-1:0] cycle_count;
  logic             busy;
  logic             done;
  logic             halted;
  logic             timed_out;
  logic             aborted;

  modport master (
    output start, mode, step, halt_in, abort,
    input  cpu_rst, cpu_ce, cycle_count, busy, done, halted, timed_out, aborted
  );

  modport slave (
    input  start, mode, step, halt_in, abort,
    output cpu_rst, cpu_ce, cycle_count, busy, done, halted, timed_out, aborted
  );

endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for cpu_top: holds the CPU in reset for RESET_CYCLES after
// each start, then runs it free, bounded, single-stepped or until halt, and
// reports the enabled-cycle count and why the run ended.
//   clk  : single rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : cpu_run_ctrl_if.slave
//          in  start, mode[1:0], step, halt_in, abort
//          out cpu_rst, cpu_ce, cycle_count[CNT_W-1:0], busy, done,
//              halted, timed_out, aborted
module cpu_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 20,
  parameter int unsigned CNT_W        = 32
) (
  input  logic          clk,
  input  logic          rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    RUN        = 3'd2,
    STEP_WAIT  = 3'd3,
    STEP_EXEC  = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              halted_q, halted_nxt;
  logic              timed_out_q, timed_out_nxt;
  logic              aborted_q, aborted_nxt;

  logic              cpu_rst_q;
  logic              cpu_ce_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  cnt_inc;
  logic              limit_hit;

  // Saturating increment; only mode 10 can actually reach saturation.
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign limit_hit = (mode_q != MODE_HALT) && (cnt_inc == CNT_LIMIT);

  // Next-state and datapath updates.
  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_q;
    hold_nxt      = hold_q;
    cnt_nxt       = cnt_q;
    halted_nxt    = halted_q;
    timed_out_nxt = timed_out_q;
    aborted_nxt   = aborted_q;

    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt     = RESET_HOLD;
          mode_nxt      = (bus.mode == 2'b11) ? MODE_FREE : bus.mode;
          hold_nxt      = HOLD_INIT;
          cnt_nxt       = '0;
          halted_nxt    = 1'b0;
          timed_out_nxt = 1'b0;
          aborted_nxt   = 1'b0;
        end
      end

      RESET_HOLD: begin
        // hold_q counts remaining reset cycles including the current one.
        if (hold_q <= HOLD_ONE) begin
          state_nxt = (mode_q == MODE_STEP) ? STEP_WAIT : RUN;
        end else begin
          hold_nxt = hold_q - HOLD_ONE;
        end
      end

      RUN, STEP_EXEC: begin
        // Enabled cycle: counted even when it is the terminating one.
        cnt_nxt = cnt_inc;
        if (bus.abort) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b1;
        end else if (bus.halt_in) begin
          state_nxt  = DONE;
          halted_nxt = 1'b1;
        end else if (limit_hit) begin
          state_nxt     = DONE;
          timed_out_nxt = 1'b1;
        end else if (state == STEP_EXEC) begin
          state_nxt = STEP_WAIT;
        end
      end

      STEP_WAIT: begin
        if (bus.abort) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b1;
        end else if (bus.step) begin
          state_nxt = STEP_EXEC;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State register; output flops are decoded from the next state so they
  // always equal a pure decode of the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      mode_q      <= MODE_FREE;
      hold_q      <= '0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_ce_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      mode_q      <= mode_nxt;
      hold_q      <= hold_nxt;
      cnt_q       <= cnt_nxt;
      halted_q    <= halted_nxt;
      timed_out_q <= timed_out_nxt;
      aborted_q   <= aborted_nxt;
      cpu_rst_q   <= (state_nxt == IDLE) || (state_nxt == RESET_HOLD);
      cpu_ce_q    <= (state_nxt == RUN)  || (state_nxt == STEP_EXEC);
      busy_q      <= (state_nxt != IDLE) && (state_nxt != DONE);
      done_q      <= (state_nxt == DONE);
    end
  end

  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.cpu_ce      = cpu_ce_q;
  assign bus.cycle_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.halted      = halted_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed runs on three instances (defaults,
// MAX_CYCLES=6, CNT_W=4). Expected run results are queued at start and
// checked by per-instance monitors on the rising edge of done.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  cpu_run_ctrl_if #(.CNT_W(32)) if0 ();
  cpu_run_ctrl_if #(.CNT_W(32)) if1 ();
  cpu_run_ctrl_if #(.CNT_W(4))  if2 ();

  cpu_run_ctrl #(.RESET_CYCLES(2), .MAX_CYCLES(20), .CNT_W(32)) u0 (.clk(clk), .rst(rst0), .bus(if0));
  cpu_run_ctrl #(.RESET_CYCLES(2), .MAX_CYCLES(6),  .CNT_W(32)) u1 (.clk(clk), .rst(rst1), .bus(if1));
  cpu_run_ctrl #(.RESET_CYCLES(2), .MAX_CYCLES(10), .CNT_W(4))  u2 (.clk(clk), .rst(rst2), .bus(if2));

  typedef struct packed {
    logic [31:0] cnt;
    logic        halted;
    logic        timed_out;
    logic        aborted;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t e0, e1;
  logic done0_d = 1'b0;
  logic done1_d = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic res_t mk(input int c, input logic h, input logic t, input logic a);
    res_t r;
    r.cnt       = 32'(c);
    r.halted    = h;
    r.timed_out = t;
    r.aborted   = a;
    return r;
  endfunction

  // Monitor u0: compare final status on the first DONE cycle.
  always @(negedge clk) begin
    if (if0.done && !done0_d) begin
      chk("u0_result_expected", longint'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("u0_cycle_count", if0.cycle_count, e0.cnt);
        chk("u0_halted",      if0.halted,      e0.halted);
        chk("u0_timed_out",   if0.timed_out,   e0.timed_out);
        chk("u0_aborted",     if0.aborted,     e0.aborted);
      end
    end
    done0_d <= if0.done;
  end

  // Monitor u1.
  always @(negedge clk) begin
    if (if1.done && !done1_d) begin
      chk("u1_result_expected", longint'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("u1_cycle_count", if1.cycle_count, e1.cnt);
        chk("u1_halted",      if1.halted,      e1.halted);
        chk("u1_timed_out",   if1.timed_out,   e1.timed_out);
        chk("u1_aborted",     if1.aborted,     e1.aborted);
      end
    end
    done1_d <= if1.done;
  end

  // One run on u0. Cycle 1 is the cycle after the edge that samples start.
  // halt_at/abort_ce index enabled cycles (1-based); abort_cyc/start_at/step_mask
  // index cycles. Inputs are driven at negedge, sampled on the next posedge.
  task automatic run0(input logic [1:0] m, input int halt_at, input int abort_ce,
                      input int abort_cyc, input int start_at, input logic [31:0] step_mask,
                      input int budget, output int ce_n, output int rst_cyc,
                      output int first_ce, output int done_cyc, output int max_run,
                      output longint cnt_at1);
    int cyc;
    int run;
    cyc = 0; run = 0; ce_n = 0; rst_cyc = 0; first_ce = -1; done_cyc = -1;
    max_run = 0; cnt_at1 = -1;
    @(negedge clk);
    if0.start = 1'b1;
    if0.mode  = m;
    while (cyc < budget && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if0.start = (cyc == start_at);
      if (cyc == 1) cnt_at1 = longint'(if0.cycle_count);
      if (if0.done) begin
        done_cyc = cyc;
      end else begin
        if (if0.cpu_rst) rst_cyc++;
        if (if0.cpu_ce) begin
          ce_n++;
          run++;
          if (first_ce < 0) first_ce = cyc;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if0.halt_in = if0.cpu_ce && (ce_n == halt_at);
        if0.abort   = (if0.cpu_ce && (ce_n == abort_ce)) || (cyc == abort_cyc);
        if0.step    = (cyc < 32) && step_mask[cyc[4:0]];
      end
    end
    if0.start = 1'b0; if0.halt_in = 1'b0; if0.abort = 1'b0; if0.step = 1'b0;
    chk("u0_done_within_budget", longint'(done_cyc >= 0), 1);
  endtask

  // One run on u1 with an optional halt on enabled cycle halt_at.
  task automatic run1(input logic [1:0] m, input int halt_at, input int budget,
                      output int ce_n);
    int cyc;
    bit seen;
    cyc = 0; ce_n = 0; seen = 1'b0;
    @(negedge clk);
    if1.start = 1'b1;
    if1.mode  = m;
    while (cyc < budget && !seen) begin
      @(negedge clk);
      cyc++;
      if1.start = 1'b0;
      if (if1.done) begin
        seen = 1'b1;
      end else begin
        if (if1.cpu_ce) ce_n++;
        if1.halt_in = if1.cpu_ce && (ce_n == halt_at);
      end
    end
    if1.halt_in = 1'b0;
    chk("u1_done_within_budget", longint'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     ce_n, rst_cyc, first_ce, done_cyc, max_run;
    longint cnt_at1;

    if0.start = 0; if0.mode = 0; if0.step = 0; if0.halt_in = 0; if0.abort = 0;
    if1.start = 0; if1.mode = 0; if1.step = 0; if1.halt_in = 0; if1.abort = 0;
    if2.start = 0; if2.mode = 0; if2.step = 0; if2.halt_in = 0; if2.abort = 0;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst",   if0.cpu_rst,     1);
    chk("rst_cpu_ce",    if0.cpu_ce,      0);
    chk("rst_count",     if0.cycle_count, 0);
    chk("rst_halted",    if0.halted,      0);
    chk("rst_timed_out", if0.timed_out,   0);
    chk("rst_aborted",   if0.aborted,     0);
    chk("rst_busy",      if0.busy,        0);
    chk("rst_done",      if0.done,        0);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_cpu_rst", if0.cpu_rst, 1);
    chk("idle_busy",    if0.busy,    0);

    // Mode 00 to the limit; a start while busy at cycle 10 must be ignored.
    q0.push_back(mk(20, 1'b0, 1'b1, 1'b0));
    run0(2'b00, 0, 0, 0, 10, 32'h0, 60, ce_n, rst_cyc, first_ce, done_cyc, max_run, cnt_at1);
    chk("m00_rst_cycles", rst_cyc,  2);
    chk("m00_first_ce",   first_ce, 3);
    chk("m00_ce_cycles",  ce_n,     20);
    chk("m00_done_cycle", done_cyc, 23);

    // abort while DONE is ignored.
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    @(negedge clk);
    chk("done_abort_done",    if0.done,    1);
    chk("done_abort_aborted", if0.aborted, 0);
    chk("done_abort_tmo",     if0.timed_out, 1);

    // Mode 10, halt on 7th enabled cycle.
    q0.push_back(mk(7, 1'b1, 1'b0, 1'b0));
    run0(2'b10, 7, 0, 0, 0, 32'h0, 60, ce_n, rst_cyc, first_ce, done_cyc, max_run, cnt_at1);
    chk("m10_ce_cycles",  ce_n,     7);
    chk("m10_done_cycle", done_cyc, 10);

    // Restart clears count; abort+halt together on 5th enabled cycle.
    q0.push_back(mk(5, 1'b0, 1'b0, 1'b1));
    run0(2'b00, 5, 5, 0, 0, 32'h0, 60, ce_n, rst_cyc, first_ce, done_cyc, max_run, cnt_at1);
    chk("restart_count_cleared", cnt_at1, 0);
    chk("abort_halt_ce_cycles",  ce_n,    5);

    // Single-step: steps at cycles 4, 8, 12 plus one at 9 during STEP_EXEC; abort at 16.
    q0.push_back(mk(3, 1'b0, 1'b0, 1'b1));
    run0(2'b01, 0, 0, 16, 0, 32'h0000_1310, 60, ce_n, rst_cyc, first_ce, done_cyc, max_run, cnt_at1);
    chk("step_ce_cycles",   ce_n,     3);
    chk("step_pulse_width", max_run,  1);
    chk("step_first_ce",    first_ce, 5);
    chk("step_done_cycle",  done_cyc, 17);

    // Synchronous reset in the middle of a run.
    @(negedge clk);
    if0.start = 1'b1;
    if0.mode  = 2'b00;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrun_busy",  if0.busy,        1);
    chk("midrun_count", if0.cycle_count, 6);
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    chk("midrst_cpu_rst", if0.cpu_rst,     1);
    chk("midrst_cpu_ce",  if0.cpu_ce,      0);
    chk("midrst_count",   if0.cycle_count, 0);
    chk("midrst_busy",    if0.busy,        0);
    @(negedge clk);
    chk("midrst_stays_idle", if0.busy, 0);

    // MAX_CYCLES=6: halt and limit coincide -> halted only.
    q1.push_back(mk(6, 1'b1, 1'b0, 1'b0));
    run1(2'b00, 6, 40, ce_n);
    chk("u1_halt_ce_cycles", ce_n, 6);
    // Mode 11 behaves like 00.
    q1.push_back(mk(6, 1'b0, 1'b1, 1'b0));
    run1(2'b11, 0, 40, ce_n);
    chk("u1_m11_ce_cycles", ce_n, 6);

    // CNT_W=4, mode 10 without halt: count saturates at 15, run continues.
    @(negedge clk);
    if2.start = 1'b1;
    if2.mode  = 2'b10;
    @(negedge clk);
    if2.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("sat_count",  if2.cycle_count, 15);
    chk("sat_busy",   if2.busy,        1);
    chk("sat_cpu_ce", if2.cpu_ce,      1);
    chk("sat_done",   if2.done,        0);

    repeat (3) @(negedge clk);
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
